// File: rtl/csr_sequencer.sv
// Zicsr issue controller: sequences CSR read/write/xret strobes, raises illegal-instruction traps.
// Accept->resp_valid: 3 cycles read+write, 2 otherwise; req_ready only in IDLE, no resp backpressure.
module csr_sequencer (
  input  logic        phi2,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [1:0]  xret,
  input  logic [11:0] addr_in,
  input  logic [63:0] rs1_val,
  input  logic [4:0]  uimm,
  input  logic        rd_zero,
  input  logic        rs1_zero,
  input  logic [63:0] pc,
  input  logic [1:0]  priv_level,
  input  logic        medeleg_ill,
  output logic        csr_read,
  output logic        csr_write,
  output logic        mret,
  output logic        sret,
  output logic [11:0] csr_addr,
  output logic [63:0] csr_wdata,
  input  logic [63:0] csr_rdata,
  input  logic        csr_invalid,
  output logic        take_trap,
  output logic        trap_to_s,
  output logic [63:0] trap_cause,
  output logic [63:0] trap_pc,
  output logic        resp_valid,
  output logic        resp_trap,
  output logic [63:0] rd_value
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, XRET, TRAP, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [1:0]  xret_q;
  logic [11:0] addr_q;
  logic [63:0] rs1_q;
  logic [4:0]  uimm_q;
  logic        rs1_zero_q;
  logic [63:0] pc_q;
  logic [63:0] old_q;
  logic        trapped_q;

  logic        in_is_xret, in_reserved, in_is_rw;
  logic        wr_needed;
  logic [63:0] src;
  logic [63:0] wdata;

  assign in_is_xret  = (funct3 == 3'b000) && ((xret == 2'b01) || (xret == 2'b10));
  assign in_reserved = ((funct3 == 3'b000) && !in_is_xret) || (funct3 == 3'b100);
  assign in_is_rw    = (funct3[1:0] == 2'b01);

  assign wr_needed = (op_q[1:0] == 2'b01) || !rs1_zero_q;
  assign src       = op_q[2] ? {59'b0, uimm_q} : rs1_q;

  always_comb begin
    case (op_q[1:0])
      2'b10:   wdata = old_q | src;
      2'b11:   wdata = old_q & ~src;
      default: wdata = src;
    endcase
  end

  always_ff @(posedge phi2 or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op_q       <= 3'b0;
      xret_q     <= 2'b0;
      addr_q     <= 12'b0;
      rs1_q      <= 64'b0;
      uimm_q     <= 5'b0;
      rs1_zero_q <= 1'b0;
      pc_q       <= 64'b0;
      old_q      <= 64'b0;
      trapped_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        op_q       <= funct3;
        xret_q     <= xret;
        addr_q     <= addr_in;
        rs1_q      <= rs1_val;
        uimm_q     <= uimm;
        rs1_zero_q <= rs1_zero;
        pc_q       <= pc;
        old_q      <= 64'b0;
        trapped_q  <= 1'b0;
      end
      if (state == READ) old_q <= csr_rdata;
      if (take_trap) trapped_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    csr_read   = 1'b0;
    csr_write  = 1'b0;
    mret       = 1'b0;
    sret       = 1'b0;
    csr_addr   = 12'b0;
    csr_wdata  = 64'b0;
    take_trap  = 1'b0;
    resp_valid = 1'b0;
    resp_trap  = 1'b0;
    rd_value   = 64'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (in_is_xret)                state_nxt = XRET;
          else if (in_reserved)          state_nxt = TRAP;
          else if (in_is_rw && rd_zero)  state_nxt = WRITE;
          else                           state_nxt = READ;
        end
      end
      READ: begin
        csr_read = 1'b1;
        csr_addr = addr_q;
        if (csr_invalid) begin
          take_trap = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = wr_needed ? WRITE : DONE;
        end
      end
      WRITE: begin
        // the CSR file suppresses the update itself when it flags the access
        csr_write = 1'b1;
        csr_addr  = addr_q;
        csr_wdata = wdata;
        take_trap = csr_invalid;
        state_nxt = DONE;
      end
      XRET: begin
        if (xret_q == 2'b10) begin
          if (priv_level == 2'b11) mret = 1'b1;
          else                     take_trap = 1'b1;
        end else begin
          if (priv_level != 2'b00) sret = 1'b1;
          else                     take_trap = 1'b1;
        end
        state_nxt = DONE;
      end
      TRAP: begin
        take_trap = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_trap  = trapped_q;
        rd_value   = trapped_q ? 64'b0 : old_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign trap_cause = take_trap ? 64'd2 : 64'd0;
  assign trap_pc    = take_trap ? pc_q : 64'd0;
  assign trap_to_s  = take_trap && medeleg_ill && (priv_level != 2'b11);

endmodule

// File: tb/tb_csr_sequencer.sv
// Directed bench for csr_sequencer with a small fixed-value CSR file model.
module tb_csr_sequencer;

  logic        phi2, rst;
  logic        req_valid, req_ready;
  logic [2:0]  funct3;
  logic [1:0]  xret;
  logic [11:0] addr_in;
  logic [63:0] rs1_val;
  logic [4:0]  uimm;
  logic        rd_zero, rs1_zero;
  logic [63:0] pc;
  logic [1:0]  priv_level;
  logic        medeleg_ill;
  logic        csr_read, csr_write, mret, sret;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, csr_rdata;
  logic        csr_invalid;
  logic        take_trap, trap_to_s;
  logic [63:0] trap_cause, trap_pc;
  logic        resp_valid, resp_trap;
  logic [63:0] rd_value;

  csr_sequencer dut (
    .phi2(phi2), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .xret(xret), .addr_in(addr_in), .rs1_val(rs1_val),
    .uimm(uimm), .rd_zero(rd_zero), .rs1_zero(rs1_zero), .pc(pc),
    .priv_level(priv_level), .medeleg_ill(medeleg_ill),
    .csr_read(csr_read), .csr_write(csr_write), .mret(mret), .sret(sret),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_invalid(csr_invalid),
    .take_trap(take_trap), .trap_to_s(trap_to_s), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .resp_valid(resp_valid), .resp_trap(resp_trap), .rd_value(rd_value)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  // CSR file model: fixed contents, 0xC00-range is read-only
  always_comb begin
    case (csr_addr)
      12'h340: csr_rdata = 64'h1234;
      12'h300: csr_rdata = 64'h1800;
      12'h304: csr_rdata = 64'hFF;
      12'hC00: csr_rdata = 64'h55;
      default: csr_rdata = 64'h0;
    endcase
  end
  assign csr_invalid = csr_write && (csr_addr[11:10] == 2'b11);

  int          n_rd, n_wr, n_mret, n_sret, n_trap;
  logic [63:0] last_wdata, last_cause, last_tpc;
  logic        last_tos;
  initial begin
    n_rd = 0; n_wr = 0; n_mret = 0; n_sret = 0; n_trap = 0;
    last_wdata = '0; last_cause = '0; last_tpc = '0; last_tos = 1'b0;
  end
  always @(posedge phi2) begin
    if (csr_read)  n_rd   <= n_rd + 1;
    if (csr_write) begin n_wr <= n_wr + 1; last_wdata <= csr_wdata; end
    if (mret)      n_mret <= n_mret + 1;
    if (sret)      n_sret <= n_sret + 1;
    if (take_trap) begin
      n_trap <= n_trap + 1; last_cause <= trap_cause; last_tpc <= trap_pc; last_tos <= trap_to_s;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  int b_rd, b_wr, b_mret, b_sret, b_trap;
  task automatic snap();
    b_rd = n_rd; b_wr = n_wr; b_mret = n_mret; b_sret = n_sret; b_trap = n_trap;
  endtask

  int          lat;
  logic [63:0] rdv;
  logic        rtr;

  task automatic run_op(input logic [2:0] f3, input logic [1:0] xr, input logic [11:0] a,
                        input logic [63:0] r1, input logic [4:0] ui, input logic rdz,
                        input logic rs1z, input logic [63:0] p);
    int w;
    snap();
    funct3 = f3; xret = xr; addr_in = a; rs1_val = r1; uimm = ui;
    rd_zero = rdz; rs1_zero = rs1z; pc = p; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 10) begin @(posedge phi2); #1; w++; end
    @(posedge phi2); #1;
    req_valid = 1'b0;
    chk("busy_after_accept", {63'b0, req_ready}, 64'd0);
    lat = 1;
    while (!resp_valid && lat < 10) begin @(posedge phi2); #1; lat++; end
    rdv = rd_value;
    rtr = resp_trap;
    @(posedge phi2); #1;
    chk("resp_one_cycle", {62'b0, resp_valid, req_ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; funct3 = '0; xret = '0; addr_in = '0; rs1_val = '0;
    uimm = '0; rd_zero = 1'b0; rs1_zero = 1'b0; pc = '0; priv_level = 2'b11; medeleg_ill = 1'b0;
    #12;
    chk("rst_ready", {63'b0, req_ready}, 64'd1);
    chk("rst_strobes", {58'b0, csr_read, csr_write, mret, sret, take_trap, resp_valid}, 64'd0);
    chk("rst_addr_wdata", {csr_addr, csr_wdata[51:0] | csr_wdata[63:12]}, 64'd0);
    chk("rst_rd_trap", rd_value | trap_cause | trap_pc, 64'd0);
    @(negedge phi2); rst = 1'b1;
    @(posedge phi2); #1;

    // CSRRW mscratch
    run_op(3'b001, 2'b00, 12'h340, 64'hDEAD, 5'd0, 1'b0, 1'b0, 64'h1000);
    chk("rw_lat", lat, 3);
    chk("rw_rd", rdv, 64'h1234);
    chk("rw_wdata", last_wdata, 64'hDEAD);
    chk("rw_cnt", {n_rd - b_rd, n_wr - b_wr, n_trap - b_trap}, {32'd1, 32'd1, 32'd0} >> 0 & 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rw_resp_trap", {63'b0, rtr}, 64'd0);

    // CSRRS mstatus with rs1=x0: read only
    run_op(3'b010, 2'b00, 12'h300, 64'hFFFF, 5'd0, 1'b0, 1'b1, 64'h1004);
    chk("rs0_lat", lat, 2);
    chk("rs0_rd", rdv, 64'h1800);
    chk("rs0_reads", n_rd - b_rd, 1);
    chk("rs0_writes", n_wr - b_wr, 0);

    // CSRRCI mie, uimm=5
    run_op(3'b111, 2'b00, 12'h304, 64'h0, 5'd5, 1'b0, 1'b0, 64'h1008);
    chk("rci_lat", lat, 3);
    chk("rci_wdata", last_wdata, 64'hFA);
    chk("rci_rd", rdv, 64'hFF);

    // CSRRWI with rd=x0: write only
    run_op(3'b101, 2'b00, 12'h340, 64'h0, 5'd7, 1'b1, 1'b0, 64'h100C);
    chk("rwi_lat", lat, 2);
    chk("rwi_reads", n_rd - b_rd, 0);
    chk("rwi_wdata", last_wdata, 64'h7);
    chk("rwi_rd", rdv, 64'h0);

    // CSRRS register form
    run_op(3'b010, 2'b00, 12'h340, 64'hF0000, 5'd0, 1'b0, 1'b0, 64'h1010);
    chk("rs_wdata", last_wdata, 64'hF1234);
    chk("rs_rd", rdv, 64'h1234);

    // write to read-only counter from M mode
    run_op(3'b001, 2'b00, 12'hC00, 64'h1, 5'd0, 1'b0, 1'b0, 64'h2000);
    chk("ro_lat", lat, 3);
    chk("ro_traps", n_trap - b_trap, 1);
    chk("ro_cause", last_cause, 64'd2);
    chk("ro_tpc", last_tpc, 64'h2000);
    chk("ro_tos", {63'b0, last_tos}, 64'd0);
    chk("ro_resp", {63'b0, rtr}, 64'd1);
    chk("ro_rd", rdv, 64'h0);

    // same from S mode with delegation
    priv_level = 2'b01; medeleg_ill = 1'b1;
    run_op(3'b001, 2'b00, 12'hC00, 64'h1, 5'd0, 1'b0, 1'b0, 64'h2004);
    chk("ro_s_tos", {63'b0, last_tos}, 64'd1);
    chk("ro_s_tpc", last_tpc, 64'h2004);

    // MRET from S mode is illegal
    run_op(3'b000, 2'b10, 12'h302, 64'h0, 5'd0, 1'b1, 1'b1, 64'h3000);
    chk("mret_s_lat", lat, 2);
    chk("mret_s_pulse", n_mret - b_mret, 0);
    chk("mret_s_trap", n_trap - b_trap, 1);
    chk("mret_s_resp", {63'b0, rtr}, 64'd1);

    // SRET from S mode is legal
    run_op(3'b000, 2'b01, 12'h102, 64'h0, 5'd0, 1'b1, 1'b1, 64'h3004);
    chk("sret_s_pulse", n_sret - b_sret, 1);
    chk("sret_s_trap", n_trap - b_trap, 0);

    // SRET from U mode traps
    priv_level = 2'b00; medeleg_ill = 1'b0;
    run_op(3'b000, 2'b01, 12'h102, 64'h0, 5'd0, 1'b1, 1'b1, 64'h3008);
    chk("sret_u_pulse", n_sret - b_sret, 0);
    chk("sret_u_trap", n_trap - b_trap, 1);

    // MRET from M mode
    priv_level = 2'b11;
    run_op(3'b000, 2'b10, 12'h302, 64'h0, 5'd0, 1'b1, 1'b1, 64'h300C);
    chk("mret_m_lat", lat, 2);
    chk("mret_m_pulse", n_mret - b_mret, 1);
    chk("mret_m_resp", {63'b0, rtr}, 64'd0);

    // reserved funct3
    run_op(3'b100, 2'b00, 12'h340, 64'h0, 5'd0, 1'b0, 1'b0, 64'h4000);
    chk("rsv_lat", lat, 2);
    chk("rsv_trap", n_trap - b_trap, 1);
    chk("rsv_tpc", last_tpc, 64'h4000);
    chk("rsv_reads", n_rd - b_rd, 0);

    // reset during WRITE
    snap();
    funct3 = 3'b001; addr_in = 12'h340; rs1_val = 64'hBEEF; rd_zero = 1'b0; rs1_zero = 1'b0;
    pc = 64'h5000; req_valid = 1'b1;
    @(posedge phi2); #1; req_valid = 1'b0;
    @(posedge phi2); #2;
    chk("mid_in_write", {63'b0, csr_write}, 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_ready", {63'b0, req_ready}, 64'd1);
    chk("mid_strobes", {58'b0, csr_read, csr_write, mret, sret, take_trap, resp_valid}, 64'd0);
    chk("mid_addr", {52'b0, csr_addr}, 64'd0);
    @(negedge phi2); rst = 1'b1;
    chk("mid_no_write", n_wr - b_wr, 0);
    @(posedge phi2); #1;
    run_op(3'b010, 2'b00, 12'h304, 64'h100, 5'd0, 1'b0, 1'b0, 64'h5004);
    chk("post_lat", lat, 3);
    chk("post_wdata", last_wdata, 64'h1FF);
    chk("post_rd", rdv, 64'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
